// File: rtl/trigger_watchdog_ctrl.sv
// Purpose : arm/delay/run/fault sequencer ahead of the reset/trigger manager; supervises the watchdog toggle and the instant-reset pin.
// Latency : trigger_enable rises N+1+cfg_start_delay after the arm edge sampled at N; pins add SYNC_STAGES cycles, then one registered cycle.
// Backpres: none; level/edge control inputs, always accepted.
//
// Ports:
//   clk, peripheral_aresetn        - clock, asynchronous active-low reset
//   cfg_arm                        - rising edge arms, low disarms
//   cfg_start_delay                - cycles from arm to trigger enable (sampled at arming)
//   cfg_watchdog_en                - watchdog supervision while running
//   cfg_instant_reset_en           - enables the instant-reset pin
//   cfg_fault_clear                - rising edge leaves FAULT
//   watchdog_in, instant_reset_in  - asynchronous pins
//   trigger_enable, reset_ack      - registered outputs
//   ctrl_sts                       - status word
// Optional build macro TRIGGER_WATCHDOG_CTRL_FAULT_COUNT_EN adds a saturating
// fault counter on ctrl_sts[31:16]; without it those bits read 0.

module trigger_watchdog_ctrl #(
    parameter int WATCHDOG_TIMEOUT_CYCLES = 12500000,
    parameter int START_DELAY_WIDTH       = 32,
    parameter int SYNC_STAGES             = 2
) (
    input  logic                         clk,
    input  logic                         peripheral_aresetn,
    input  logic                         cfg_arm,
    input  logic [START_DELAY_WIDTH-1:0] cfg_start_delay,
    input  logic                         cfg_watchdog_en,
    input  logic                         cfg_instant_reset_en,
    input  logic                         cfg_fault_clear,
    input  logic                         watchdog_in,
    input  logic                         instant_reset_in,
    output logic                         trigger_enable,
    output logic                         reset_ack,
    output logic [31:0]                  ctrl_sts
);

    localparam int WD_W = (WATCHDOG_TIMEOUT_CYCLES > 2) ? $clog2(WATCHDOG_TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t                 state;
    logic [START_DELAY_WIDTH-1:0] delay_cnt;
    logic [WD_W-1:0]        wd_cnt;
    logic                   cause_wd;
    logic                   cause_ir;
    logic [SYNC_STAGES-1:0] wd_sync_q;
    logic [SYNC_STAGES-1:0] ir_sync_q;
    logic                   wd_sync;
    logic                   ir_sync;
    logic                   wd_prev;
    logic                   arm_prev;
    logic                   clr_prev;
    logic                   arm_edge;
    logic                   clr_edge;
    logic                   wd_event;
    logic                   ir_hit;
    logic                   wd_timeout;
    logic                   go_fault;
    logic [15:0]            fault_sts;

    // Pin synchronizers plus the one-cycle history used for watchdog edge detection.
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            wd_sync_q <= '0;
            ir_sync_q <= '0;
            wd_prev   <= 1'b0;
        end else begin
            wd_sync_q <= {wd_sync_q[SYNC_STAGES-2:0], watchdog_in};
            ir_sync_q <= {ir_sync_q[SYNC_STAGES-2:0], instant_reset_in};
            wd_prev   <= wd_sync;
        end
    end

    // History resets high so a control bit held high through reset release is not an edge.
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            arm_prev <= 1'b1;
            clr_prev <= 1'b1;
        end else begin
            arm_prev <= cfg_arm;
            clr_prev <= cfg_fault_clear;
        end
    end

    assign wd_sync    = wd_sync_q[SYNC_STAGES-1];
    assign ir_sync    = ir_sync_q[SYNC_STAGES-1];
    assign arm_edge   = cfg_arm & ~arm_prev;
    assign clr_edge   = cfg_fault_clear & ~clr_prev;
    assign wd_event   = wd_sync ^ wd_prev;
    assign ir_hit     = ir_sync & cfg_instant_reset_en;
    // An edge arriving on the timeout cycle itself rescues the run.
    assign wd_timeout = cfg_watchdog_en && !wd_event && (wd_cnt == WD_W'(WATCHDOG_TIMEOUT_CYCLES - 1));
    assign go_fault   = ((state == DELAY) && ir_hit) || ((state == RUN) && (ir_hit || wd_timeout));

    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            state          <= IDLE;
            delay_cnt      <= '0;
            wd_cnt         <= '0;
            trigger_enable <= 1'b0;
            reset_ack      <= 1'b0;
            cause_wd       <= 1'b0;
            cause_ir       <= 1'b0;
        end else if (go_fault) begin
            state          <= FAULT;
            trigger_enable <= 1'b0;
            reset_ack      <= 1'b1;
            // Instant reset outranks the watchdog timeout when both hit together.
            if (ir_hit) cause_ir <= 1'b1;
            else        cause_wd <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    trigger_enable <= 1'b0;
                    reset_ack      <= 1'b0;
                    wd_cnt         <= '0;
                    if (arm_edge) begin
                        if (cfg_start_delay == '0) begin
                            state          <= RUN;
                            trigger_enable <= 1'b1;
                        end else begin
                            state     <= DELAY;
                            delay_cnt <= cfg_start_delay;
                        end
                    end
                end
                DELAY: begin
                    if (!cfg_arm) begin
                        state <= IDLE;
                    end else if (delay_cnt == START_DELAY_WIDTH'(1)) begin
                        state          <= RUN;
                        trigger_enable <= 1'b1;
                        wd_cnt         <= '0;
                    end else begin
                        delay_cnt <= delay_cnt - START_DELAY_WIDTH'(1);
                    end
                end
                RUN: begin
                    if (!cfg_arm) begin
                        state          <= IDLE;
                        trigger_enable <= 1'b0;
                        wd_cnt         <= '0;
                    end else if (!cfg_watchdog_en || wd_event) begin
                        wd_cnt <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                FAULT: begin
                    if (clr_edge) begin
                        state     <= IDLE;
                        reset_ack <= 1'b0;
                        cause_wd  <= 1'b0;
                        cause_ir  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TRIGGER_WATCHDOG_CTRL_FAULT_COUNT_EN
    logic [15:0] fault_cnt;

    // Survives fault clears; only reset zeroes it.
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            fault_cnt <= '0;
        end else if (go_fault && (fault_cnt != 16'hFFFF)) begin
            fault_cnt <= fault_cnt + 16'd1;
        end
    end

    assign fault_sts = fault_cnt;
`else
    assign fault_sts = 16'h0000;
`endif

    assign ctrl_sts = {fault_sts, 8'h00, ir_sync, wd_sync, cause_ir, cause_wd,
                       reset_ack, trigger_enable, state};

endmodule

// File: tb/tb_trigger_watchdog_ctrl.sv
module tb_trigger_watchdog_ctrl;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        peripheral_aresetn;
    logic        cfg_arm;
    logic [31:0] cfg_start_delay;
    logic        cfg_watchdog_en;
    logic        cfg_instant_reset_en;
    logic        cfg_fault_clear;
    logic        watchdog_in;
    logic        instant_reset_in;
    logic        trigger_enable;
    logic        reset_ack;
    logic [31:0] ctrl_sts;

    int n_tests  = 0;
    int n_fail   = 0;
    // Reference model: pin levels as seen after synchronisation settles, and faults since reset.
    int m_faults = 0;
    bit m_wd     = 1'b0;
    bit m_ir     = 1'b0;

    always #4 clk = ~clk;

    trigger_watchdog_ctrl #(
        .WATCHDOG_TIMEOUT_CYCLES(TO),
        .START_DELAY_WIDTH(32),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .peripheral_aresetn(peripheral_aresetn),
        .cfg_arm(cfg_arm),
        .cfg_start_delay(cfg_start_delay),
        .cfg_watchdog_en(cfg_watchdog_en),
        .cfg_instant_reset_en(cfg_instant_reset_en),
        .cfg_fault_clear(cfg_fault_clear),
        .watchdog_in(watchdog_in),
        .instant_reset_in(instant_reset_in),
        .trigger_enable(trigger_enable),
        .reset_ack(reset_ack),
        .ctrl_sts(ctrl_sts)
    );

    // Status word the specification prescribes for a given state and cause set.
    function automatic logic [31:0] exp_sts(input int st, input bit c4, input bit c5);
        logic [15:0] fc;
`ifdef TRIGGER_WATCHDOG_CTRL_FAULT_COUNT_EN
        fc = (m_faults > 65535) ? 16'hFFFF : 16'(m_faults);
`else
        fc = 16'h0000;
`endif
        return {fc, 8'h00, m_ir, m_wd, c5, c4, (st == 3), (st == 2), st[1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        cfg_fault_clear = 1'b1;
        step(1);
        cfg_fault_clear = 1'b0;
    endtask

    // Arms at the next edge N and follows the delay count until RUN.
    task automatic arm_and_check(input int d);
        cfg_start_delay = d;
        cfg_arm = 1'b1;
        step(1);
        if (d == 0) begin
            chk("arm_d0_run", ctrl_sts, exp_sts(2, 0, 0));
        end else begin
            chk("arm_delay", ctrl_sts, exp_sts(1, 0, 0));
            cfg_start_delay = $urandom;  // must not disturb the running delay
            for (int j = 1; j <= d; j++) begin
                step(1);
                chk("delay_seq", ctrl_sts, exp_sts((j == d) ? 2 : 1, 0, 0));
            end
        end
        chk("te_port", {31'b0, trigger_enable}, 32'd1);
    endtask

    initial begin
        #5ms;
        n_fail++;
        $display("FAIL global_timeout: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int d;
        int iv;
        int total;
        logic [31:0] e;

        peripheral_aresetn   = 1'b0;
        cfg_arm              = 1'b0;
        cfg_start_delay      = '0;
        cfg_watchdog_en      = 1'b0;
        cfg_instant_reset_en = 1'b0;
        cfg_fault_clear      = 1'b0;
        watchdog_in          = 1'b0;
        instant_reset_in     = 1'b0;

        #20;
        chk("reset_sts", ctrl_sts, 32'h0);
        chk("reset_outs", {30'b0, reset_ack, trigger_enable}, 32'h0);
        step(1);
        peripheral_aresetn = 1'b1;
        step(3);
        chk("idle_after_reset", ctrl_sts, exp_sts(0, 0, 0));

        // Start-delay sequencing: fixed boundaries plus one random delay.
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: d = 10;
                1: d = 0;
                2: d = 1;
                default: d = $urandom_range(2, 40);
            endcase
            arm_and_check(d);
            cfg_arm = 1'b0;
            step(1);
            chk("disarm_run", ctrl_sts, exp_sts(0, 0, 0));
        end

        // Disarm during DELAY.
        cfg_start_delay = 30;
        cfg_arm = 1'b1;
        step(5);
        cfg_arm = 1'b0;
        step(1);
        chk("disarm_delay", ctrl_sts, exp_sts(0, 0, 0));

        // Reset mid-DELAY, arm held high across release.
        cfg_start_delay = 50;
        cfg_arm = 1'b1;
        step(6);
        chk("pre_rst_delay", ctrl_sts, exp_sts(1, 0, 0));
        peripheral_aresetn = 1'b0;
        #1;
        chk("rst_mid_delay", ctrl_sts, 32'h0);
        m_faults = 0;
        step(2);
        peripheral_aresetn = 1'b1;
        step(5);
        chk("arm_high_release1", ctrl_sts, exp_sts(0, 0, 0));

        // Reset mid-RUN.
        cfg_arm = 1'b0;
        step(1);
        cfg_start_delay = 0;
        cfg_arm = 1'b1;
        step(3);
        chk("pre_rst_run", ctrl_sts, exp_sts(2, 0, 0));
        peripheral_aresetn = 1'b0;
        #1;
        chk("rst_mid_run", ctrl_sts, 32'h0);
        step(2);
        peripheral_aresetn = 1'b1;
        step(20);
        chk("arm_high_release2", ctrl_sts, exp_sts(0, 0, 0));

        // Watchdog supervision.
        cfg_arm = 1'b0;
        step(1);
        cfg_arm = 1'b1;
        step(1);
        chk("run_entry", ctrl_sts, exp_sts(2, 0, 0));
        step(300);
        chk("wd_disabled_hold", ctrl_sts, exp_sts(2, 0, 0));
        cfg_watchdog_en = 1'b1;
        total = 0;
        while (total < 2000) begin
            iv = $urandom_range(10, 90);
            step(iv);
            total += iv;
            chk("wd_alive", ctrl_sts, exp_sts(2, 0, 0));
            watchdog_in = ~watchdog_in;
            m_wd = ~m_wd;
        end
        // Next toggle lands so its synced edge coincides with the timeout cycle.
        step(100);
        chk("wd_pre_boundary", ctrl_sts, exp_sts(2, 0, 0));
        watchdog_in = ~watchdog_in;
        m_wd = ~m_wd;
        step(102);
        chk("wd_event_wins", ctrl_sts, exp_sts(2, 0, 0));
        step(1);
        m_faults++;
        chk("wd_timeout_fault", ctrl_sts, exp_sts(3, 1, 0));
        chk("wd_fault_outs", {30'b0, reset_ack, trigger_enable}, 32'h2);

        // Clear with arm held high: back to IDLE, no re-arm until a fresh edge.
        pulse_clear();
        chk("clear_idle", ctrl_sts, exp_sts(0, 0, 0));
        step(5);
        chk("no_rearm", ctrl_sts, exp_sts(0, 0, 0));
        cfg_start_delay = 1000;
        cfg_arm = 1'b0;
        step(1);
        cfg_arm = 1'b1;
        step(1);
        chk("rearm_delay", ctrl_sts, exp_sts(1, 0, 0));

        // Instant reset during DELAY.
        cfg_instant_reset_en = 1'b1;
        step($urandom_range(1, 20));
        instant_reset_in = 1'b1;
        m_ir = 1'b1;
        step(2);
        chk("ir_delay_sync", ctrl_sts, exp_sts(1, 0, 0));
        step(1);
        m_faults++;
        chk("ir_delay_fault", ctrl_sts, exp_sts(3, 0, 1));
        instant_reset_in = 1'b0;
        m_ir = 1'b0;
        step(3);
        chk("ir_sticky", ctrl_sts, exp_sts(3, 0, 1));
        cfg_arm = 1'b0;
        pulse_clear();
        chk("ir_clear", ctrl_sts, exp_sts(0, 0, 0));

        // Instant reset pin ignored while disabled.
        cfg_instant_reset_en = 1'b0;
        cfg_watchdog_en = 1'b0;
        cfg_start_delay = 0;
        cfg_arm = 1'b1;
        step(1);
        chk("run_entry2", ctrl_sts, exp_sts(2, 0, 0));
        instant_reset_in = 1'b1;
        m_ir = 1'b1;
        step(4);
        chk("ir_disabled", ctrl_sts, exp_sts(2, 0, 0));
        instant_reset_in = 1'b0;
        m_ir = 1'b0;
        step(3);
        chk("ir_disabled_after", ctrl_sts, exp_sts(2, 0, 0));

        // Instant reset during RUN.
        cfg_instant_reset_en = 1'b1;
        step(2);
        instant_reset_in = 1'b1;
        m_ir = 1'b1;
        step(2);
        chk("ir_run_sync", ctrl_sts, exp_sts(2, 0, 0));
        step(1);
        m_faults++;
        chk("ir_run_fault", ctrl_sts, exp_sts(3, 0, 1));
        instant_reset_in = 1'b0;
        m_ir = 1'b0;
        step(3);
        pulse_clear();
        chk("final_idle", ctrl_sts, exp_sts(0, 0, 0));
        e = exp_sts(0, 0, 0);
        chk("fault_count", {16'h0, ctrl_sts[31:16]}, {16'h0, e[31:16]});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trigger_watchdog_ctrl.md
Name: trigger_watchdog_ctrl

Overview:
- Sequencer ahead of the reset/trigger manager.
- Arms acquisition on software request and waits a programmable start delay, then asserts the internal trigger enable.
- While running, supervises the external watchdog toggle and the instant-reset pin.
- On a fault it drops the trigger enable, latches the cause and holds reset_ack until software clears it.

Parameters:
- WATCHDOG_TIMEOUT_CYCLES, 12500000, cycles without a watchdog edge before fault (100 ms at 125 MHz); must be >= 2.
- START_DELAY_WIDTH, 32, width of start-delay counter.
- SYNC_STAGES, 2, synchronizer depth for async pin inputs; must be >= 2.

Ports:
- clk  in  1  system clock, 125 MHz
- peripheral_aresetn  in  1  reset, asynchronous, active-low
- cfg_arm  in  1  level; rising edge arms the sequence, low disarms
- cfg_start_delay  in  START_DELAY_WIDTH  cycles from arm to trigger enable
- cfg_watchdog_en  in  1  enable watchdog supervision in RUN
- cfg_instant_reset_en  in  1  enable instant-reset pin
- cfg_fault_clear  in  1  rising edge leaves FAULT
- watchdog_in  in  1  async pin, master toggles it periodically
- instant_reset_in  in  1  async pin, high = immediate stop
- trigger_enable  out  1  internal trigger enable to reset manager
- reset_ack  out  1  high while in FAULT
- ctrl_sts  out  32  status word

Behaviour:

Reset
- On peripheral_aresetn low, asynchronously:
  - state = IDLE.
  - All counters = 0.
  - trigger_enable = 0, reset_ack = 0, cause bits = 0, synchronizers = 0.
- Edge-detect history registers for cfg_arm and cfg_fault_clear reset to 1. An input held high through reset deassertion produces no edge.

Input handling
- watchdog_in and instant_reset_in pass through SYNC_STAGES flops. All logic uses the synced values.
- A watchdog event is any edge (rise or fall) of synced watchdog_in.
- All outputs are registered.

States (encoding 0..3)
- IDLE (0)
  - trigger_enable = 0.
  - Arm edge sampled at cycle N:
    - cfg_start_delay = 0 → RUN; trigger_enable = 1 at N+1.
    - otherwise → DELAY; load counter = cfg_start_delay.
- DELAY (1)
  - Counter decrements each cycle. At counter == 1 → RUN, so trigger_enable rises at N+1+cfg_start_delay.
  - cfg_arm low → IDLE.
  - Instant reset (synced pin & cfg_instant_reset_en) → FAULT.
- RUN (2)
  - trigger_enable = 1. Watchdog counter cleared on entry.
  - Watchdog counter behaviour:
    - Counts up each cycle.
    - Cleared on a watchdog event.
    - Held at 0 while cfg_watchdog_en = 0.
  - Exit priorities:
    1. Instant reset → FAULT, cause bit 5.
    2. Counter reaches WATCHDOG_TIMEOUT_CYCLES−1 with no event that cycle → FAULT, cause bit 4.
    3. cfg_arm low → IDLE.
  - A watchdog event in the same cycle as the timeout count wins: counter clears, no fault.
- FAULT (3)
  - trigger_enable = 0 and reset_ack = 1, both from the first FAULT cycle.
  - Cause bits are sticky.
  - cfg_fault_clear rising edge → IDLE; cause bits cleared.
  - After clear, a new cfg_arm rising edge is required to re-arm. Arm held high stays in IDLE.
- Arm edges seen outside IDLE are ignored.
- cfg_start_delay is sampled only at arming. Later changes do not affect the current DELAY.

Status (ctrl_sts)
- [1:0] state
- [2] trigger_enable
- [3] reset_ack
- [4] watchdog-timeout cause
- [5] instant-reset cause
- [6] synced watchdog_in
- [7] synced instant_reset_in
- [15:8] 0
- [31:16] fault count, or 0 if feature disabled

Optional Feature:
- Macro: TRIGGER_WATCHDOG_CTRL_FAULT_COUNT_EN
- Defined:
  - 16-bit counter increments on each transition into FAULT.
  - Saturates at 0xFFFF and is not cleared by cfg_fault_clear.
  - Cleared only by reset.
  - Driven on ctrl_sts[31:16].
- Undefined: no counter; ctrl_sts[31:16] = 0.

Test Plan:
1. Arm, cfg_start_delay=10 → trigger_enable rises exactly 11 cycles after the arm edge sample; ctrl_sts[1:0] goes 0→1→2. Repeat with delay=0 → rise at N+1.
2. RUN, cfg_watchdog_en=1, WATCHDOG_TIMEOUT_CYCLES=100, watchdog toggled every 50 cycles for 2000 cycles → stays RUN. Stop toggling → FAULT 100 cycles after the last synced edge; reset_ack=1, sts[4]=1, trigger_enable=0.
3. instant_reset_in pulsed high while in DELAY and while in RUN with cfg_instant_reset_en=1 → FAULT, sts[5]=1. Same pulse with enable=0 → no state change.
4. In FAULT, cfg_fault_clear edge with cfg_arm held high → IDLE, reset_ack=0, causes cleared, no re-arm. Toggle cfg_arm 0→1 → DELAY.
5. peripheral_aresetn asserted mid-DELAY and mid-RUN → immediate IDLE, all outputs 0. cfg_arm held high across reset release → remains IDLE.
6. Feature defined: force 3 faults → ctrl_sts[31:16]=3, unchanged by fault_clear. Feature undefined → 0.
